mul_div_unit: RTL and testbench

- Multi-cycle 16-bit unsigned multiply/divide unit sitting directly downstream of the operand muxes: operand_x from Mux_x, operand_y from Mux_y.
- Started by the control unit with a one-cycle start pulse; results written back through the data-register path.
- Iterative radix-2: shift-add multiply, restoring divide; one iteration per clock.

---
 rtl/mul_div_unit_pkg.sv | 16 +
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding and the iteration count.
package mul_div_unit_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int ITERATIONS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
// Both datapaths share the FSM and iteration counter; results are held in
// dedicated registers so they stay stable until the next operation completes.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int bus_width   = 16,
  parameter int count_width = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [bus_width-1:0] operand_x,
  input  logic [bus_width-1:0] operand_y,
  output logic                 busy,
  output logic                 done,
  output logic [bus_width-1:0] result_lo,
  output logic [bus_width-1:0] result_hi,
  output logic                 div_by_zero
);

  state_t state_reg, state_next;

  logic                   op_reg;
  logic [bus_width-1:0]   operand_reg;   // multiplicand for MUL, divisor for DIV
  logic [2*bus_width:0]   acc_reg;       // MUL accumulator {carry, hi, lo}
  logic [bus_width:0]     rem_reg;       // DIV partial remainder
  logic [bus_width-1:0]   quot_reg;      // DIV dividend in, quotient out
  logic [count_width-1:0] count_reg;
  logic [bus_width-1:0]   result_lo_reg;
  logic [bus_width-1:0]   result_hi_reg;
  logic                   dbz_reg;

  logic                   accept;
  logic                   zero_div;
  logic                   last_iter;
  logic [bus_width:0]     mul_sum;
  logic [2*bus_width:0]   mul_next;
  logic [bus_width+1:0]   div_shift;
  logic [bus_width+1:0]   div_trial;
  logic [bus_width:0]     rem_next;
  logic [bus_width-1:0]   quot_next;

  assign accept    = start && (state_reg != RUN);
  assign zero_div  = (op == OP_DIV) && (operand_y == '0);
  assign last_iter = (count_reg == count_width'(bus_width - 1));

  // One radix-2 step of each datapath, computed from the current registers.
  always_comb begin
    mul_sum   = {acc_reg[2*bus_width], acc_reg[2*bus_width-1:bus_width]}
              + {1'b0, (acc_reg[0] ? operand_reg : {bus_width{1'b0}})};
    mul_next  = {1'b0, mul_sum, acc_reg[bus_width-1:1]};
    div_shift = {rem_reg, quot_reg[bus_width-1]};
    div_trial = div_shift - {2'b00, operand_reg};
    rem_next  = div_shift[bus_width:0];
    quot_next = {quot_reg[bus_width-2:0], 1'b0};
    if (!div_trial[bus_width+1]) begin
      rem_next  = div_trial[bus_width:0];
      quot_next = {quot_reg[bus_width-2:0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a start in DONE is accepted just like in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = zero_div ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate while running, capture results on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg        <= OP_MUL;
      operand_reg   <= '0;
      acc_reg       <= '0;
      rem_reg       <= '0;
      quot_reg      <= '0;
      count_reg     <= '0;
      result_lo_reg <= '0;
      result_hi_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      op_reg      <= op;
      operand_reg <= (op == OP_MUL) ? operand_x : operand_y;
      acc_reg     <= {{(bus_width+1){1'b0}}, operand_y};
      rem_reg     <= '0;
      quot_reg    <= operand_x;
      count_reg   <= '0;
      dbz_reg     <= 1'b0;
      if (zero_div) begin
        result_lo_reg <= '1;
        result_hi_reg <= operand_x;
        dbz_reg       <= 1'b1;
      end
    end else if (state_reg == RUN) begin
      count_reg <= count_reg + count_width'(1);
      if (op_reg == OP_MUL) acc_reg <= mul_next;
      else begin
        rem_reg  <= rem_next;
        quot_reg <= quot_next;
      end
      if (last_iter) begin
        if (op_reg == OP_MUL) begin
          result_lo_reg <= mul_next[bus_width-1:0];
          result_hi_reg <= mul_next[2*bus_width-1:bus_width];
        end else begin
          result_lo_reg <= quot_next;
          result_hi_reg <= rem_next[bus_width-1:0];
        end
      end
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign result_lo   = result_lo_reg;
  assign result_hi   = result_hi_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results computed
// with plain arithmetic; a negedge monitor pops and compares on every done.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] operand_x = '0;
  logic [15:0] operand_y = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  mul_div_unit #(.bus_width(16), .count_width(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_x(operand_x), .operand_y(operand_y),
    .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          due;
    int          busy_len;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          $display("txn %s: lo=0x%04h hi=0x%04h dbz=%0b", e.name, result_lo, result_hi, div_by_zero);
          check({e.name, "_lo"}, 32'(result_lo), 32'(e.lo));
          check({e.name, "_hi"}, 32'(result_hi), 32'(e.hi));
          check({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
          check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          check({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.busy_len));
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one operation at the current negedge; caller guarantees the unit is not running.
  task automatic issue(input string name, input logic o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [31:0] p;
    e.name = name;
    e.dbz = 1'b0;
    if (o == 1'b0) begin
      p = 32'(x) * 32'(y);
      e.lo = p[15:0];
      e.hi = p[31:16];
    end else if (y == 16'h0) begin
      e.lo = 16'hFFFF;
      e.hi = x;
      e.dbz = 1'b1;
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    e.due = cyc + (e.dbz ? 1 : 17);
    e.busy_len = e.dbz ? 0 : 16;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    operand_x = x;
    operand_y = y;
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom);
    operand_x = 16'($urandom);
    operand_y = 16'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    int dones;
    logic o;
    logic [15:0] x, y;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lo", 32'(result_lo), 32'd0);
    check("rst_hi", 32'(result_hi), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue("mul_1234_5678", 1'b0, 16'h1234, 16'h5678); wait_done();
    issue("mul_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF); wait_done();
    @(negedge clk);
    issue("mul_0_abcd", 1'b0, 16'h0000, 16'hABCD); wait_done();
    issue("div_1000_7", 1'b1, 16'h03E8, 16'h0007); wait_done();
    issue("div_5_9", 1'b1, 16'h0005, 16'h0009); wait_done();
    issue("div_by_zero", 1'b1, 16'h1234, 16'h0000); wait_done();
    issue("div_after_dbz", 1'b1, 16'hFFFF, 16'h0001); wait_done();

    // Start while busy is ignored
    @(negedge clk);
    issue("mul_ignore", 1'b0, 16'h00FF, 16'h0101);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; operand_x = 16'h7777; operand_y = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start in the DONE cycle is accepted with no bubble
    issue("b2b_div", 1'b1, 16'hBEEF, 16'h0013);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done();

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    issue("mul_aborted", 1'b0, 16'h1111, 16'h2222);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_lo", 32'(result_lo), 32'd0);
    check("abort_hi", 32'(result_hi), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Randomized operations, mixing gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(o ? "rnd_div" : "rnd_mul", o, x, y);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
